// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - round-robin arbiter sharing one i2c master among NUM_REQ requesters; optional watchdog under I2C_TIMEOUT_EN
module i2c_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int START_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_rw,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   err,
    output logic                 busy,
    output logic                 m_start,
    output logic [6:0]           m_addr,
    output logic [7:0]           m_data,
    output logic                 m_rw,
    input  logic                 m_ready
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int SCW  = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] owner;
    logic [IDXW-1:0] pick_idx;
    logic [IDXW-1:0] cand_idx;
    logic [IDXW:0]   cand_sum;
    logic            pick_found;
    logic [SCW-1:0]  start_cnt;
    logic            finish;
    logic            timeout;

    // Reject parameter values outside the supported range at elaboration
    if (NUM_REQ < 2 || NUM_REQ > 8 || START_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("i2c_req_arbiter: parameter out of range");
    end

    assign busy    = (state != IDLE);
    assign m_start = (state == ISSUE);

    // Round-robin search: scan offsets high to low so the nearest set bit at or after rr_ptr wins
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        cand_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_ptr} + (IDXW+1)'(k);
            if (cand_sum >= (IDXW+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDXW+1)'(NUM_REQ);
            end
            cand_idx = cand_sum[IDXW-1:0];
            if (req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

`ifdef I2C_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES);
    logic [TCW-1:0] to_cnt;
    logic           to_hit;

    assign to_hit = (to_cnt == TCW'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: cleared while issuing so it starts at zero on entry to WAIT_BUSY
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            err    <= '0;
        end else begin
            err <= '0;
            if (state == ISSUE) begin
                to_cnt <= '0;
            end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (timeout) begin
                err <= grant;
            end
        end
    end
`else
    logic to_hit;

    assign to_hit = 1'b0;
    assign err    = '0;
`endif

    // Next-state logic; completion has priority over the watchdog in WAIT_DONE
    always_comb begin
        state_next = state;
        finish     = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (m_ready && pick_found) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (start_cnt == SCW'(START_CYCLES - 1)) begin
                    state_next = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (to_hit) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else if (!m_ready) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (m_ready) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end else if (to_hit) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus winner latch, start counter, done pulse and pointer advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            grant     <= '0;
            done      <= '0;
            m_addr    <= '0;
            m_data    <= '0;
            m_rw      <= 1'b0;
            start_cnt <= '0;
        end else begin
            state <= state_next;
            done  <= '0;
            if (state == IDLE) begin
                start_cnt <= '0;
                if (state_next == ISSUE) begin
                    owner  <= pick_idx;
                    grant  <= NUM_REQ'(1) << pick_idx;
                    m_addr <= req_addr[pick_idx*7 +: 7];
                    m_data <= req_data[pick_idx*8 +: 8];
                    m_rw   <= req_rw[pick_idx];
                end
            end else if (state == ISSUE) begin
                start_cnt <= start_cnt + 1'b1;
            end
            if (finish || timeout) begin
                done   <= grant;
                grant  <= '0;
                rr_ptr <= (owner == IDXW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb/tb_i2c_req_arbiter.sv - table-driven and scoreboard checks for i2c_req_arbiter
module tb_i2c_req_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [27:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_rw;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        busy;
    logic        m_start;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;
    logic        m_rw;
    logic        m_ready;

    i2c_req_arbiter #(
        .NUM_REQ(4),
        .START_CYCLES(5),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_rw(req_rw),
        .grant(grant),
        .done(done),
        .err(err),
        .busy(busy),
        .m_start(m_start),
        .m_addr(m_addr),
        .m_data(m_data),
        .m_rw(m_rw),
        .m_ready(m_ready)
    );

    typedef struct {
        logic [3:0] g;
        logic [6:0] a;
        logic [7:0] d;
        logic       r;
    } exp_t;

    typedef struct {
        logic [3:0] req;
        int         idx;
    } vec_t;

    int         vectors;
    int         miscompares;
    exp_t       sb[$];
    exp_t       e;
    vec_t       tbl[11];
    logic [6:0] addr_tab[4];
    logic [7:0] data_tab[4];
    logic       rw_tab[4];
    logic       start_prev;
    int         start_len;
    logic [3:0] cur_owner;
    logic       flag;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_inputs();
        for (int i = 0; i < 4; i++) begin
            req_addr[7*i +: 7] = addr_tab[i];
            req_data[8*i +: 8] = data_tab[i];
            req_rw[i]          = rw_tab[i];
        end
    endtask

    // Push expectation, raise req, check m_start one clock later
    task automatic issue(input logic [3:0] mask, input int idx);
        exp_t x;
        x.g = 4'(1) << idx;
        x.a = addr_tab[idx];
        x.d = data_tab[idx];
        x.r = rw_tab[idx];
        sb.push_back(x);
        req = mask;
        @(negedge clk);
        chk("start_latency", {31'd0, m_start}, 32'd1);
    endtask

    task automatic wait_start_end();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_start && n < 20);
        chk("start_end", {31'd0, m_start}, 32'd0);
    endtask

    task automatic serve_master(input int busy_len);
        wait_start_end();
        m_ready = 1'b0;
        repeat (busy_len) @(negedge clk);
        m_ready = 1'b1;
    endtask

    task automatic wait_done(input int idx, input logic [3:0] exp_err);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 4'd0 && n < 30);
        chk("done", {28'd0, done}, {28'd0, 4'(1) << idx});
        chk("err", {28'd0, err}, {28'd0, exp_err});
        chk("addr_at_done", {25'd0, m_addr}, {25'd0, addr_tab[idx]});
    endtask

    // Scoreboard monitor: pop on m_start rise, check start width and done ownership
    always @(negedge clk) begin
        if (!rst) begin
            start_prev = 1'b0;
            start_len  = 0;
        end else begin
            if (m_start) begin
                if (!start_prev) begin
                    if (sb.size() == 0) begin
                        chk("sb_nonempty", 32'd0, 32'd1);
                    end else begin
                        e = sb.pop_front();
                        cur_owner = e.g;
                        chk("grant", {28'd0, grant}, {28'd0, e.g});
                        chk("m_addr", {25'd0, m_addr}, {25'd0, e.a});
                        chk("m_data", {24'd0, m_data}, {24'd0, e.d});
                        chk("m_rw", {31'd0, m_rw}, {31'd0, e.r});
                    end
                end
                start_len++;
            end else if (start_prev) begin
                chk("start_len", start_len, 32'd5);
                start_len = 0;
            end
            if (done != 4'd0) begin
                chk("done_owner", {28'd0, done}, {28'd0, cur_owner});
                chk("grant_at_done", {28'd0, grant}, 32'd0);
            end
            start_prev = m_start;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cur_owner   = 4'd0;
        start_prev  = 1'b0;
        start_len   = 0;
        addr_tab = '{7'h50, 7'h21, 7'h3C, 7'h6E};
        data_tab = '{8'hAA, 8'h5B, 8'hC3, 8'h0F};
        rw_tab   = '{1'b0, 1'b1, 1'b0, 1'b1};

        tbl[0]  = '{4'b0001, 0};
        tbl[1]  = '{4'b1001, 3};
        tbl[2]  = '{4'b1111, 0};
        tbl[3]  = '{4'b1111, 1};
        tbl[4]  = '{4'b1111, 2};
        tbl[5]  = '{4'b1111, 3};
        tbl[6]  = '{4'b1111, 0};
        tbl[7]  = '{4'b0101, 2};
        tbl[8]  = '{4'b0011, 0};
        tbl[9]  = '{4'b1000, 3};
        tbl[10] = '{4'b0110, 1};

        rst     = 1'b0;
        req     = 4'd0;
        m_ready = 1'b1;
        load_inputs();
        repeat (3) @(negedge clk);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_done", {28'd0, done}, 32'd0);
        chk("rst_err", {28'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_m_start", {31'd0, m_start}, 32'd0);
        chk("rst_m_addr", {25'd0, m_addr}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_m_rw", {31'd0, m_rw}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Arbitration order table
        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].req, tbl[i].idx);
            chk("busy", {31'd0, busy}, 32'd1);
            serve_master(2);
            wait_done(tbl[i].idx, 4'd0);
        end

        // Owner 2 keeps its latched request after inputs change and req drops
        issue(4'b0100, 2);
        wait_start_end();
        m_ready = 1'b0;
        @(negedge clk);
        req_addr[20:14] = 7'h11;
        req_data[23:16] = 8'h99;
        req = 4'b0000;
        @(negedge clk);
        chk("hold_addr", {25'd0, m_addr}, 32'h3C);
        chk("hold_grant", {28'd0, grant}, 32'b0100);
        m_ready = 1'b1;
        wait_done(2, 4'd0);
        load_inputs();

        // Master busy in IDLE blocks arbitration
        m_ready = 1'b0;
        req = 4'b0010;
        repeat (5) @(negedge clk);
        chk("blocked_grant", {28'd0, grant}, 32'd0);
        chk("blocked_start", {31'd0, m_start}, 32'd0);
        chk("blocked_busy", {31'd0, busy}, 32'd0);
        m_ready = 1'b1;
        issue(4'b0010, 1);
        serve_master(3);
        wait_done(1, 4'd0);

        // Asynchronous reset in ISSUE aborts silently and resets rr_ptr
        issue(4'b0100, 2);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_m_start", {31'd0, m_start}, 32'd0);
        chk("arst_grant", {28'd0, grant}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        req = 4'd0;
        flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done != 4'd0) flag = 1'b1;
        end
        chk("arst_no_done", {31'd0, flag}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        issue(4'b0101, 0);
        serve_master(2);
        wait_done(0, 4'd0);

        // Master never goes busy after start
        issue(4'b0110, 1);
        wait_start_end();
`ifdef I2C_TIMEOUT_EN
        flag = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done != 4'd0 || err != 4'd0) flag = 1'b1;
        end
        chk("to_early", {31'd0, flag}, 32'd0);
        @(negedge clk);
        chk("to_done", {28'd0, done}, 32'b0010);
        chk("to_err", {28'd0, err}, 32'b0010);
        issue(4'b0100, 2);
        serve_master(2);
        wait_done(2, 4'd0);
        req = 4'd0;
`else
        flag = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done != 4'd0 || err != 4'd0) flag = 1'b1;
        end
        chk("stuck_no_done", {31'd0, flag}, 32'd0);
        chk("stuck_busy", {31'd0, busy}, 32'd1);
        chk("stuck_grant", {28'd0, grant}, 32'b0010);
        #2 rst = 1'b0;
        req = 4'd0;
        @(negedge clk);
        rst = 1'b1;
`endif
        @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
